// File: rtl/csa_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLOCK = 4;
  localparam int DEFAULT_NB    = DEFAULT_WIDTH / DEFAULT_BLOCK;

  function automatic int calc_nb(input int width, input int block);
    return width / block;
  endfunction

  // Legal geometry: whole number of blocks, at least one block of at least one bit.
  function automatic bit width_ok(input int width, input int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/carry_select_dual_block.sv
// One carry-select block: sum and carry-out for both possible block carry-ins.
module carry_select_dual_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic             cout0,
  output logic [BLOCK-1:0] sum1,
  output logic             cout1
);

  assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
  assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Two-stage carry-select adder: stage 1 registers dual block results, stage 2
// resolves the block carry chain. Valid/ready on both sides, throughput 1.
module pipelined_carry_select_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NB = calc_nb(WIDTH, BLOCK);

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_carry_select_adder: WIDTH must be a nonzero multiple of BLOCK");
  end

  logic [NB-1:0][BLOCK-1:0] sum0_d, sum1_d, sum0_q, sum1_q;
  logic [NB-1:0]            cout0_d, cout1_d, cout0_q, cout1_q;
  logic                     cin_q, msb_prop_q, s1_valid_q;

  logic [WIDTH-1:0]         sum_d, sum_q;
  logic                     cout_d, cout_q, ovf_d, ovf_q, out_valid_q;

  logic                     s1_en, s2_en, accept;

  // Back-pressure flows from out_ready straight through to in_ready.
  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid && s1_en;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    carry_select_dual_block #(.BLOCK(BLOCK)) u_dual (
      .a     (a[k*BLOCK +: BLOCK]),
      .b     (b[k*BLOCK +: BLOCK]),
      .sum0  (sum0_d[k]),
      .cout0 (cout0_d[k]),
      .sum1  (sum1_d[k]),
      .cout1 (cout1_d[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sum0_q     <= '0;
      sum1_q     <= '0;
      cout0_q    <= '0;
      cout1_q    <= '0;
      cin_q      <= 1'b0;
      msb_prop_q <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q <= accept;
      if (accept) begin
        sum0_q     <= sum0_d;
        sum1_q     <= sum1_d;
        cout0_q    <= cout0_d;
        cout1_q    <= cout1_d;
        cin_q      <= cin;
        msb_prop_q <= a[WIDTH-1] ^ b[WIDTH-1];
      end
    end
  end

  // Carry select chain: each block's true carry-in picks its precomputed half.
  always_comb begin : carry_chain
    logic carry;
    sum_d = '0;
    carry = cin_q;
    for (int k = 0; k < NB; k++) begin
      sum_d[k*BLOCK +: BLOCK] = carry ? sum1_q[k] : sum0_q[k];
      carry                   = carry ? cout1_q[k] : cout0_q[k];
    end
    cout_d = carry;
    ovf_d  = carry ^ (msb_prop_q ^ sum_d[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (s2_en) out_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_en) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for pipelined_carry_select_adder (WIDTH=16, BLOCK=4): directed
// corner cases, back-pressure, reset mid-stall, then random traffic.
module tb_pipelined_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t        m;
    logic [16:0] r;
    r      = {1'b0, x} + {1'b0, y} + {16'b0, c};
    m.sum  = r[15:0];
    m.cout = r[16];
    m.ovf  = (x[15] == y[15]) && (r[15] != x[15]);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle, score the handshakes of the coming rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                               input logic c, input logic ordy, output logic accepted);
    exp_t e;
    in_valid  = v;
    a         = av;
    b         = bv;
    cin       = c;
    out_ready = ordy;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", 32'(sum), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("sum", 32'(sum), 32'(e.sum));
        checkOutput("cout", 32'(cout), 32'(e.cout));
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
    if (accepted) expQ.push_back(model(av, bv, c));
    @(negedge clk);
  endtask

  task automatic sendBeat(input logic [15:0] av, input logic [15:0] bv, input logic c);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) applyStimulus(1'b1, av, bv, c, 1'b1, acc);
    if (!acc) checkOutput("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Full-width carry out; also checks the two-edge latency.
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, acc);
    checkOutput("first_accept", 32'(acc), 32'd1);
    checkOutput("lat_after_1", 32'(out_valid), 32'd0);
    idle(1);
    checkOutput("lat_after_2", 32'(out_valid), 32'd1);
    idle(3);

    sendBeat(16'h7FFF, 16'h0001, 1'b0);
    sendBeat(16'h8000, 16'h8000, 1'b0);
    sendBeat(16'h0FFF, 16'h0000, 1'b1);
    idle(4);

    // Back-pressure: two beats fill the pipe, the third must wait.
    applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, acc);
    checkOutput("bp_acc1", 32'(acc), 32'd1);
    applyStimulus(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, acc);
    checkOutput("bp_acc2", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, acc);
      checkOutput("bp_in_ready", 32'(acc), 32'd0);
      checkOutput("bp_hold_sum", 32'(sum), 32'h0002);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    sendBeat(16'h0003, 16'h0003, 1'b0);
    idle(4);

    // Reset while both stages are occupied and stalled.
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, acc);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_rst_sum", 32'(sum), 32'hFFFE);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_sum", 32'(sum), 32'd0);
    checkOutput("mid_rst_cout", 32'(cout), 32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, acc);
    checkOutput("post_rst_accept", 32'(acc), 32'd1);
    checkOutput("post_rst_lat1", 32'(out_valid), 32'd0);
    idle(1);
    checkOutput("post_rst_lat2", 32'(out_valid), 32'd1);
    checkOutput("post_rst_sum", 32'(sum), 32'h5555);
    idle(4);

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                    ($urandom % 4) != 0, acc);
    end
    idle(10);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
